// File: rtl/craps_pkg.sv
// craps_pkg: game states and dice-sum constants shared by the craps controller
package craps_pkg;
    localparam int SUM_W = 4;
    localparam logic [SUM_W-1:0] SEVEN     = 4'd7;
    localparam logic [SUM_W-1:0] ELEVEN    = 4'd11;
    localparam logic [SUM_W-1:0] SNAKE     = 4'd2;
    localparam logic [SUM_W-1:0] ACE_DEUCE = 4'd3;
    localparam logic [SUM_W-1:0] BOXCARS   = 4'd12;
    typedef enum logic [2:0] {IDLE, COME_OUT, POINT, WIN, LOSE} state_t;
endpackage

// File: rtl/craps_if.sv
// craps_if: roll/start inputs and game status outputs of the craps controller
interface craps_if #(parameter int CNT_W = 8, parameter int SCORE_W = 8);
    logic               start;
    logic [2:0]         dice_a;
    logic [2:0]         dice_b;
    logic               dice_valid;
    logic [3:0]         point;
    logic [3:0]         sum;
    logic               win;
    logic               lose;
    logic               busy;
    logic [CNT_W-1:0]   roll_cnt;
    logic [SCORE_W-1:0] wins;
    logic [SCORE_W-1:0] losses;
    logic               dice_err;
    modport master (output start, dice_a, dice_b, dice_valid,
                    input point, sum, win, lose, busy, roll_cnt, wins, losses, dice_err);
    modport slave  (input start, dice_a, dice_b, dice_valid,
                    output point, sum, win, lose, busy, roll_cnt, wins, losses, dice_err);
endinterface

// File: rtl/craps_rule_eval.sv
// craps_rule_eval: combinational die legality, sum and win/lose classification
module craps_rule_eval
    import craps_pkg::*;
(
    input  logic [2:0]       dice_a,
    input  logic [2:0]       dice_b,
    input  logic             in_point,
    input  logic [SUM_W-1:0] point,
    output logic             legal,
    output logic [SUM_W-1:0] sum,
    output logic             win,
    output logic             lose
);
    // classify the roll against come-out rules or the stored point
    always_comb begin
        legal = (dice_a != 3'd0) && (dice_a != 3'd7) && (dice_b != 3'd0) && (dice_b != 3'd7);
        sum   = SUM_W'(dice_a) + SUM_W'(dice_b);
        win   = in_point ? (sum == point) : (sum == SEVEN || sum == ELEVEN);
        lose  = in_point ? (sum == SEVEN) : (sum == SNAKE || sum == ACE_DEUCE || sum == BOXCARS);
    end
endmodule

// File: rtl/craps_ctrl.sv
// craps_ctrl: craps game state machine with point, roll counter and scoreboard
module craps_ctrl
    import craps_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int SCORE_W = 8
) (
    input  logic clk,
    input  logic reset,
    craps_if.slave bus
);
    state_t           state;
    logic             legal;
    logic             r_win;
    logic             r_lose;
    logic [SUM_W-1:0] r_sum;

    craps_rule_eval u_eval (
        .dice_a   (bus.dice_a),
        .dice_b   (bus.dice_b),
        .in_point (state == POINT),
        .point    (bus.point),
        .legal    (legal),
        .sum      (r_sum),
        .win      (r_win),
        .lose     (r_lose)
    );

    // game FSM; status flags are registered alongside every state change
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            bus.point    <= '0;
            bus.sum      <= '0;
            bus.win      <= 1'b0;
            bus.lose     <= 1'b0;
            bus.busy     <= 1'b0;
            bus.roll_cnt <= '0;
            bus.wins     <= '0;
            bus.losses   <= '0;
            bus.dice_err <= 1'b0;
        end else begin
            bus.dice_err <= 1'b0;
            if (bus.start) begin
                state        <= COME_OUT;
                bus.point    <= '0;
                bus.sum      <= '0;
                bus.roll_cnt <= '0;
                bus.win      <= 1'b0;
                bus.lose     <= 1'b0;
                bus.busy     <= 1'b1;
            end else if (bus.dice_valid && (state == COME_OUT || state == POINT)) begin
                if (!legal) begin
                    bus.dice_err <= 1'b1;
                end else begin
                    bus.sum      <= r_sum;
                    bus.roll_cnt <= bus.roll_cnt + CNT_W'(bus.roll_cnt != '1);
                    if (r_win) begin
                        state    <= WIN;
                        bus.win  <= 1'b1;
                        bus.busy <= 1'b0;
                        bus.wins <= bus.wins + SCORE_W'(bus.wins != '1);
                    end else if (r_lose) begin
                        state      <= LOSE;
                        bus.lose   <= 1'b1;
                        bus.busy   <= 1'b0;
                        bus.losses <= bus.losses + SCORE_W'(bus.losses != '1);
                    end else if (state == COME_OUT) begin
                        state     <= POINT;
                        bus.point <= r_sum;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_craps_ctrl.sv
// tb_craps_ctrl: directed and random checks of craps_ctrl against a rule-level model
module tb_craps_ctrl;
    localparam int CW   = 3;
    localparam int SW   = 3;
    localparam int CMAX = (1 << CW) - 1;
    localparam int SMAX = (1 << SW) - 1;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    // model: playing=1 while a game is open, pt==0 means come-out roll
    int m_playing, m_pt, m_sum, m_win, m_lose, m_rc, m_wins, m_losses, m_err;

    craps_if #(.CNT_W(CW), .SCORE_W(SW)) bus ();
    craps_ctrl #(.CNT_W(CW), .SCORE_W(SW)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic mstep(input logic r, input logic s, input logic dv, input int a, input int b);
        int t;
        m_err = 0;
        if (r) begin
            m_playing = 0; m_pt = 0; m_sum = 0; m_win = 0; m_lose = 0;
            m_rc = 0; m_wins = 0; m_losses = 0;
        end else if (s) begin
            m_playing = 1; m_pt = 0; m_sum = 0; m_rc = 0; m_win = 0; m_lose = 0;
        end else if (dv && m_playing == 1) begin
            if (a < 1 || a > 6 || b < 1 || b > 6) begin
                m_err = 1;
            end else begin
                t = a + b;
                m_sum = t;
                m_rc = (m_rc < CMAX) ? m_rc + 1 : CMAX;
                if (m_pt == 0) begin
                    if (t == 7 || t == 11) m_win = 1;
                    else if (t == 2 || t == 3 || t == 12) m_lose = 1;
                    else m_pt = t;
                end else begin
                    if (t == m_pt) m_win = 1;
                    else if (t == 7) m_lose = 1;
                end
                if (m_win == 1) begin
                    m_playing = 0;
                    m_wins = (m_wins < SMAX) ? m_wins + 1 : SMAX;
                end
                if (m_lose == 1) begin
                    m_playing = 0;
                    m_losses = (m_losses < SMAX) ? m_losses + 1 : SMAX;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("point",    32'(bus.point),    m_pt);
        chk("sum",      32'(bus.sum),      m_sum);
        chk("win",      32'(bus.win),      m_win);
        chk("lose",     32'(bus.lose),     m_lose);
        chk("busy",     32'(bus.busy),     m_playing);
        chk("roll_cnt", 32'(bus.roll_cnt), m_rc);
        chk("wins",     32'(bus.wins),     m_wins);
        chk("losses",   32'(bus.losses),   m_losses);
        chk("dice_err", 32'(bus.dice_err), m_err);
    endtask

    task automatic cyc(input logic r, input logic s, input logic dv, input int a, input int b);
        reset = r;
        bus.start = s;
        bus.dice_valid = dv;
        bus.dice_a = 3'(a);
        bus.dice_b = 3'(b);
        @(posedge clk);
        mstep(r, s, dv, a, b);
        #1;
        check_all();
    endtask

    function automatic int rdie();
        return ($urandom_range(0, 9) == 0) ? 7 * int'($urandom_range(0, 1)) : int'($urandom_range(1, 6));
    endfunction

    initial begin
        cyc(1, 0, 0, 0, 0);
        chk("reset_busy", 32'(bus.busy), 0);
        cyc(0, 0, 1, 3, 3);
        chk("idle_roll_err", 32'(bus.dice_err), 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 3, 4);
        chk("natural_win", 32'(bus.win), 1);
        chk("natural_sum", 32'(bus.sum), 7);
        cyc(0, 0, 1, 2, 2);
        chk("held_win", 32'(bus.win), 1);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 1, 1);
        chk("snake_lose", 32'(bus.lose), 1);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 2, 2);
        chk("point4", 32'(bus.point), 4);
        cyc(0, 0, 1, 1, 5);
        cyc(0, 0, 1, 3, 1);
        chk("point_win_cnt", 32'(bus.roll_cnt), 3);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 5, 5);
        cyc(0, 0, 1, 6, 1);
        chk("seven_out", 32'(bus.lose), 1);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 4);
        chk("bad_die_err", 32'(bus.dice_err), 1);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 4, 7);
        cyc(0, 0, 1, 4, 4);
        cyc(0, 1, 1, 6, 5);
        chk("start_over_roll_win", 32'(bus.win), 0);
        cyc(0, 0, 1, 4, 4);
        for (int i = 0; i < 10; i++) cyc(0, 0, 1, 1, 2 + (i % 2));
        chk("roll_cnt_sat", 32'(bus.roll_cnt), CMAX);
        cyc(1, 1, 1, 3, 4);
        chk("reset_mid_point", 32'(bus.point), 0);
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 1) == 1, rdie(), rdie());
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/craps_ctrl.md
CRAPS_CTRL -- requirements
Module: craps_ctrl

Interface
REQ-001 Parameter CNT_W, default 8, is the width of the per-game roll counter.
REQ-002 Parameter SCORE_W, default 8, is the width of the win and loss score counters.
REQ-003 clk  in  1  single system clock; all logic on posedge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  one-cycle pulse that begins a new game.
REQ-006 dice_a  in  3  value of the first die, legal range 1..6.
REQ-007 dice_b  in  3  value of the second die, legal range 1..6.
REQ-008 dice_valid  in  1  one-cycle strobe; dice_a and dice_b are valid this cycle.
REQ-009 point  out  4  stored point value; 0 when no point is set.
REQ-010 sum  out  4  registered sum of the last accepted roll.
REQ-011 win  out  1  high while the state is WIN.
REQ-012 lose  out  1  high while the state is LOSE.
REQ-013 busy  out  1  high while the state is COME_OUT or POINT.
REQ-014 roll_cnt  out  CNT_W  accepted rolls in the current game; saturates at all-ones.
REQ-015 wins  out  SCORE_W  games won since reset; saturates.
REQ-016 losses  out  SCORE_W  games lost since reset; saturates.
REQ-017 dice_err  out  1  one-cycle pulse when an illegal die value is strobed.

Function
REQ-018 States SHALL be IDLE, COME_OUT, POINT, WIN and LOSE; all outputs registered.
REQ-019 A roll SHALL be accepted only when dice_valid=1, state is COME_OUT or POINT, start=0, and both dice are in 1..6.
REQ-020 Accepted roll: sum <= dice_a+dice_b, computed 4 bits wide (range 2..12); roll_cnt increments with saturation.
REQ-021 COME_OUT, accepted sum 7 or 11 -> WIN; sum 2, 3 or 12 -> LOSE; otherwise point <= sum and state -> POINT.
REQ-022 POINT, accepted sum==point -> WIN; sum 7 -> LOSE; otherwise stay in POINT with point unchanged.
REQ-023 Outcome latency: win/lose and sum SHALL be visible on the first edge after the dice_valid cycle.
REQ-024 On entry to WIN, wins increments by 1 (saturating); on entry to LOSE, losses increments by 1 (saturating).
REQ-025 A start pulse in any state SHALL set state to COME_OUT and clear point, sum and roll_cnt; wins and losses are kept.
REQ-026 start and dice_valid in the same cycle: start SHALL take effect and the roll SHALL be ignored, with no count and no dice_err.
REQ-027 dice_valid in IDLE, WIN or LOSE SHALL be ignored, with no counter change and no dice_err.
REQ-028 Illegal die value (0 or 7) with dice_valid in COME_OUT or POINT SHALL pulse dice_err for one cycle, with no state change and no count.
REQ-029 WIN and LOSE SHALL hold until start or reset.
REQ-030 start during COME_OUT or POINT SHALL abandon the game and record neither a win nor a loss.

Reset
REQ-031 reset SHALL force state IDLE and all outputs to 0 on the next edge, overriding start and dice_valid.
REQ-032 reset mid-game SHALL discard the point and both scores; no win or loss is recorded.

Structure
REQ-033 Package craps_pkg SHALL hold the state enum and the constants SUM_W=4, SEVEN=7, ELEVEN=11, SNAKE=2, ACE_DEUCE=3 and BOXCARS=12.
REQ-034 The rule evaluation (legality check, sum and classification) SHALL be a combinational sub-module, craps_rule_eval; state, point and counters stay in craps_ctrl.

Verification
REQ-035 reset, start, roll (3,4) -> the next cycle shows win=1, sum=7, wins=1, roll_cnt=1.
REQ-036 start, roll (1,1) -> lose=1, sum=2, losses=1, point=0.
REQ-037 start, rolls (2,2), (1,5), (3,1) -> POINT with point=4 after the first roll, still POINT after the second, win=1 after the third, roll_cnt=3.
REQ-038 start, rolls (5,5), (6,1) -> point=10, then lose=1, losses=1.
REQ-039 Roll (0,4) in COME_OUT -> dice_err pulses for one cycle, roll_cnt=0 and the state stays COME_OUT; roll (3,3) in IDLE -> no change and no dice_err.
REQ-040 Same-cycle start and roll (6,5) while in POINT -> COME_OUT with point=0 and roll_cnt=0, no win; reset during POINT -> IDLE with all outputs 0.
